// File: rtl/stopwatch_display.sv
`default_nettype none
// stopwatch_display: synchronises the counter value, converts it to BCD with a
// sequential double-dabble engine and scans it onto a 4-digit common-anode display.
// Revision: 1.0
module stopwatch_display #(
   parameter int COUNT_SIZE = 8,
   parameter int SCAN_DIV   = 5000
) (
   input  logic                  CLK_5MHz,
   input  logic                  reset,
   input  logic [COUNT_SIZE-1:0] count,
   input  logic                  blank_lead,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [3:0]            an,
   output logic                  bcd_valid
);

   localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int c_IT_W  = (COUNT_SIZE > 1) ? $clog2(COUNT_SIZE) : 1;
   localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);
   localparam logic [c_IT_W-1:0]  c_IT_LAST  = c_IT_W'(COUNT_SIZE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   logic [COUNT_SIZE-1:0] s1_q, s2_q, s3_q;
   logic                  stable;

   state_t                state_q, state_d;
   logic [COUNT_SIZE-1:0] bin_q, bin_d;
   logic [COUNT_SIZE-1:0] last_q, last_d;
   logic [15:0]           bcd_q, bcd_d;
   logic [11:0]           bcd_adj;
   logic [c_IT_W-1:0]     iter_q, iter_d;
   logic [15:0]           disp_q, disp_d;
   logic                  valid_q, valid_d;

   logic [c_PRE_W-1:0]    presc_q;
   logic [1:0]            idx_q;
   logic [6:0]            seg_q, seg_d;
   logic [3:0]            an_q;
   logic [3:0]            digit;
   logic                  lead_zero;

   // Plain two-flop synchroniser plus a third stage for the stability compare.
   always_ff @(posedge CLK_5MHz) begin
      s1_q <= count;
      s2_q <= s1_q;
      s3_q <= s2_q;
   end

   assign stable = (s2_q == s3_q);

   always_ff @(posedge CLK_5MHz) begin
      if (reset) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         last_q  <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         disp_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         last_q  <= last_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         disp_q  <= disp_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      last_d  = last_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      disp_d  = disp_q;
      valid_d = valid_q;

      // The thousands nibble is at most 4 before any shift when the value is
      // below 10000, so only the lower three nibbles ever need the +3 fix-up.
      bcd_adj = bcd_q[11:0];
      for (int n = 0; n < 3; n++) begin
         if (bcd_q[4*n +: 4] >= 4'd5) begin
            bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (stable && ((s2_q != last_q) || !valid_q)) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            bin_d   = s2_q;
            last_d  = s2_q;
            bcd_d   = '0;
            iter_d  = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            bcd_d  = {bcd_q[14:12], bcd_adj, bin_q[COUNT_SIZE-1]};
            bin_d  = bin_q << 1;
            iter_d = iter_q + 1'b1;
            if (iter_q == c_IT_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            disp_d  = bcd_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   always_comb begin
      digit = disp_q[{idx_q, 2'b00} +: 4];
      case (idx_q)
         2'd1:    lead_zero = (disp_q[15:4] == 12'd0);
         2'd2:    lead_zero = (disp_q[15:8] == 8'd0);
         2'd3:    lead_zero = (disp_q[15:12] == 4'd0);
         default: lead_zero = 1'b0;
      endcase
      if (!valid_q || (blank_lead && lead_zero)) begin
         seg_d = 7'h7F;
      end else begin
         seg_d = seg_enc(digit);
      end
   end

   // an and seg are both registered from idx_q, so they always stay aligned.
   always_ff @(posedge CLK_5MHz) begin
      if (reset) begin
         presc_q <= '0;
         idx_q   <= 2'd0;
         seg_q   <= 7'h7F;
         an_q    <= 4'hF;
      end else begin
         if (presc_q == c_PRE_LAST) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
         end else begin
            presc_q <= presc_q + 1'b1;
         end
         an_q  <= ~(4'b0001 << idx_q);
         seg_q <= seg_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign dp        = 1'b1;
   assign bcd_valid = valid_q;

endmodule
`default_nettype wire
